// File: rtl/uart_rx.sv
// Oversampled 8N1-style serial receiver with a valid/ready output handshake.
// Optional parity stage is built in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  state_t               w_state_nxt;
  logic [TW-1:0]        w_tick_nxt;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_overrun_err_nxt;
  logic                 w_bit_end;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_bad_nxt;
  logic w_parity_err_nxt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_bit_end = tick && (r_tick_cnt == FULL_M1);

  always_comb begin
    w_state_nxt       = r_state;
    w_tick_nxt        = r_tick_cnt;
    w_bit_nxt         = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_data_nxt        = r_data;
    w_valid_nxt       = r_valid & ~rx_ready;
    w_frame_err_nxt   = 1'b0;
    w_overrun_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt     = r_par_bad;
    w_parity_err_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (r_tick_cnt == HALF_M1) begin
            // A start bit that is high again at its midpoint was only a glitch.
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end else if (tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_tick_nxt       = '0;
          w_par_bad_nxt    = (r_rx_s != ((^r_shift) ^ PARITY_ODD));
          w_parity_err_nxt = w_par_bad_nxt;
          w_state_nxt      = S_STOP;
        end else if (tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_tick_nxt = '0;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par_bad) begin
              w_data_nxt = r_data;
            end else
`endif
            // A word consumed on this same clk frees the holding register.
            if (!r_valid || rx_ready) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_overrun_err_nxt = 1'b1;
            end
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else if (tick) begin
          w_tick_nxt = r_tick_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_tick_cnt    <= w_tick_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      r_data        <= w_data_nxt;
      r_valid       <= w_valid_nxt;
      r_frame_err   <= w_frame_err_nxt;
      r_overrun_err <= w_overrun_err_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad     <= w_par_bad_nxt;
      r_parity_err  <= w_parity_err_nxt;
`endif
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
  assign rx_busy     = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
`else
  assign rx_busy     = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_STOP);
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver paired with the team's UART transmitter. It consumes the serial line that the transmitter drives and recovers parallel words from it. Line format is 8N1-style framing: start bit low, LSB-first data, stop bit high. Timing comes from a shared oversampling tick at OVERSAMPLE x baud, produced by the same baud generator that feeds the transmitter. Received words are presented on a valid/ready handshake toward the downstream consumer (FIFO or core logic).

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 16, tick pulses per bit period; even number, at least 4

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0
rx  input  1  serial line, asynchronous to clk, idle high
tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx_ready  input  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1
rx_data  output  DATA_BITS  last accepted frame payload
rx_valid  output  1  rx_data holds an unconsumed word
rx_busy  output  1  a frame is in progress (START through STOP)
frame_err  output  1  one-clk pulse: stop bit sampled low
overrun_err  output  1  one-clk pulse: frame completed while rx_valid=1

Behaviour:
- Reset (reset=0, async): state=IDLE, sync flops=1, counters=0, shift_reg=0, rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0. A reset mid-frame aborts the frame immediately and delivers no partial word.
- rx passes through a 2-flop synchronizer that resets to 1. Only the synchronized rx_s is used. This adds 2 clk of latency.
- tick_cnt has width $clog2(OVERSAMPLE). It advances only on cycles with tick=1 and wraps to 0 after reaching OVERSAMPLE-1. bit_cnt has width $clog2(DATA_BITS+1).
- IDLE: on rx_s=0, go to START with tick_cnt=0. rx_busy=0 in IDLE.
- START: on each tick, tick_cnt++. When tick arrives with tick_cnt=OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: treat as a glitch. Return to IDLE with no error.
- DATA: when tick arrives with tick_cnt=OVERSAMPLE-1, shift rx_s in at the MSB (shift_reg = {rx_s, shift_reg[DATA_BITS-1:1]}) and increment bit_cnt. After the DATA_BITS-th sample, go to STOP with tick_cnt=0.
- STOP: when tick arrives with tick_cnt=OVERSAMPLE-1, sample the stop bit:
  - rx_s=1 and rx_valid=0: rx_data<=shift_reg, rx_valid<=1. Go to IDLE.
  - rx_s=1 and rx_valid=1: overrun_err pulses for 1 clk. The new word is dropped and rx_data/rx_valid are unchanged. Go to IDLE.
  - rx_s=0: frame_err pulses for 1 clk and no word is delivered. Go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. rx_busy=0. This prevents a held-low line from retriggering frames.
- rx_busy=1 exactly in START, DATA and STOP.
- Handshake: rx_valid clears on the clk where rx_valid&rx_ready=1. rx_data is stable while rx_valid=1.
- Simultaneous accept and completion: if rx_ready consumes the current word on the same clk a new stop bit is accepted, the new word loads, rx_valid stays 1, and no overrun is flagged.
- tick high with rx changing: only the synchronized value at the sampling tick matters.
- No resynchronization occurs mid-frame. Edges inside a frame are ignored.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: adds parameter PARITY_ODD (default 0) and a PARITY state between DATA and STOP.
  - PARITY samples one bit at tick_cnt=OVERSAMPLE-1.
  - Expected parity = ^shift_reg ^ PARITY_ODD.
  - On mismatch, a new output parity_err pulses for 1 clk in place of word delivery. The STOP check still runs and can additionally raise frame_err.
- Not defined: no PARITY state, no parity_err port, and the frame is exactly 1+DATA_BITS+1 bits.

Test Plan:
- Reset low mid-frame, then release: all outputs 0, rx_busy=0; a subsequent clean frame with 0xA5 -> rx_data=0xA5.
- 8N1 frame 0x3C with OVERSAMPLE=16 and tick every 4 clk, rx_ready=1 -> rx_valid high 1 clk, rx_data=0x3C, frame_err=0.
- rx low for 5 ticks then high (glitch) -> back to IDLE, rx_valid=0, no error pulses.
- Frame 0x55 with stop bit driven 0, line held low 40 ticks then high -> frame_err pulses once, no rx_valid, stays in BREAK until high; next frame 0x0F received correctly.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 retained, overrun_err pulses once at the second stop bit; rx_ready on the same clk as the second stop bit -> rx_data=0x22, no overrun.
- Back-to-back frames 0x00, 0xFF, 0x81 from uart_tx loopback sharing tick -> all three received in order, rx_busy low between frames.
